// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg
//   Configurable UART receiver: 5..9 data bits (LSB first), optional odd/even
//   parity, 1 or 2 stop bits. Two-flop input synchroniser, mid-start glitch
//   rejection, parity/framing/overrun error pulses and a valid/ready output
//   holding register.
//
// Ports
//   clk   system clock
//   rst   synchronous active-low reset
//   ce    clock enable, every register (synchroniser and handshake too) holds when low
//   di    asynchronous serial line, idle high
//   po    received word, valid while dv = 1
//   dv    output word valid
//   rdy   consumer ready, transfer on dv & rdy & ce
//   perr  one-cycle pulse, parity mismatch
//   ferr  one-cycle pulse, a stop bit sampled low
//   ovr   one-cycle pulse, a good frame was lost because dv was still high
module uart_rx_cfg #(
   parameter int CLKS_PER_BIT   = 3200,
   parameter int CLKS_PER_BIT_W = 12,
   parameter int DATA_BITS      = 8,
   parameter int PARITY         = 0,
   parameter int STOP_BITS      = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ce,
   input  logic                 di,
   output logic [DATA_BITS-1:0] po,
   output logic                 dv,
   input  logic                 rdy,
   output logic                 perr,
   output logic                 ferr,
   output logic                 ovr
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;
   localparam logic [2:0] S_WAIT   = 3'd5;

   localparam logic [CLKS_PER_BIT_W-1:0] TICK_V = CLKS_PER_BIT_W'(CLKS_PER_BIT - 1);
   localparam logic [CLKS_PER_BIT_W-1:0] HALF_V = CLKS_PER_BIT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
   localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

   logic                      s1, s2;
   logic [2:0]                state;
   logic [CLKS_PER_BIT_W-1:0] cnt;
   logic [3:0]                bcnt;
   logic [DATA_BITS-1:0]      sr;
   logic                      par_bad;
   logic                      stop_bad;

   logic tick;
   logic par_x;
   logic par_mis;
   logic ferr_c;

   assign tick    = (cnt == TICK_V);
   assign par_x   = (^sr) ^ s2;
   // odd mode wants data^parity = 1, even mode wants 0
   assign par_mis = (PARITY == 1) ? ~par_x : par_x;
   // includes the stop bit being sampled this very cycle
   assign ferr_c  = stop_bad | ~s2;

   always_ff @(posedge clk) begin
      if (!rst) begin
         s1       <= 1'b1;
         s2       <= 1'b1;
         state    <= S_IDLE;
         cnt      <= '0;
         bcnt     <= '0;
         sr       <= '0;
         par_bad  <= 1'b0;
         stop_bad <= 1'b0;
         po       <= '0;
         dv       <= 1'b0;
         perr     <= 1'b0;
         ferr     <= 1'b0;
         ovr      <= 1'b0;
      end else if (ce) begin
         s1   <= di;
         s2   <= s1;
         perr <= 1'b0;
         ferr <= 1'b0;
         ovr  <= 1'b0;
         if (dv && rdy) dv <= 1'b0;
         // free-running wrap; states that need a fresh count clear it on entry
         cnt <= tick ? '0 : cnt + 1'b1;
         case (state)
            S_IDLE: begin
               cnt      <= '0;
               bcnt     <= '0;
               par_bad  <= 1'b0;
               stop_bad <= 1'b0;
               if (!s2) state <= S_START;
            end
            S_START: begin
               if (cnt == HALF_V) begin
                  cnt   <= '0;
                  // line back high at mid-start: glitch, drop silently
                  state <= s2 ? S_IDLE : S_DATA;
               end
            end
            S_DATA: begin
               if (tick) begin
                  sr   <= {s2, sr[DATA_BITS-1:1]};
                  bcnt <= bcnt + 1'b1;
                  if (bcnt == LAST_DATA) begin
                     bcnt  <= '0;
                     state <= (PARITY != 0) ? S_PARITY : S_STOP;
                  end
               end
            end
            S_PARITY: begin
               if (tick) begin
                  par_bad <= par_mis;
                  state   <= S_STOP;
               end
            end
            S_STOP: begin
               if (tick) begin
                  bcnt <= bcnt + 1'b1;
                  if (!s2) stop_bad <= 1'b1;
                  if (bcnt == LAST_STOP) begin
                     if (ferr_c) begin
                        ferr  <= 1'b1;
                        state <= S_WAIT;
                     end else if (par_bad) begin
                        perr  <= 1'b1;
                        state <= S_IDLE;
                     end else if (dv && !rdy) begin
                        ovr   <= 1'b1;
                        state <= S_IDLE;
                     end else begin
                        // also covers a transfer in this cycle: dv stays set
                        po    <= sr;
                        dv    <= 1'b1;
                        state <= S_IDLE;
                     end
                  end
               end
            end
            S_WAIT: begin
               // hold off through a break so the low line is not a new start
               cnt <= '0;
               if (s2) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
